// File: rtl/aes_sbox_share_arbiter_pkg.sv
// Shared tags and arbitration-mode encodings for the S-box sharing arbiter.
package aes_sbox_share_arbiter_pkg;

  typedef enum logic {
    TAG_DP = 1'b0,
    TAG_KS = 1'b1
  } tag_e;

  localparam int ARB_RR      = 0;
  localparam int ARB_KEYPRIO = 1;

endpackage

// File: rtl/aes_sbox_share_arbiter_arb2.sv
// Two-way DP/KS grant logic: round-robin pointer or KS priority with a starvation guard.
module aes_sbox_share_arbiter_arb2
  import aes_sbox_share_arbiter_pkg::*;
#(
  parameter int KEY_PRIORITY = ARB_RR,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dp_valid,
  input  logic       ks_valid,
  input  logic       accept,
  output logic [1:0] grant
);

  localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  tag_e          rr_ptr;
  tag_e          pick;
  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (STARVE_LIMIT != 0) && (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    grant = '0;
    pick  = rr_ptr;
    if (dp_valid && ks_valid) begin
      if (KEY_PRIORITY == ARB_KEYPRIO) pick = starved ? TAG_DP : TAG_KS;
      grant[pick] = 1'b1;
    end else if (dp_valid) begin
      grant[TAG_DP] = 1'b1;
    end else if (ks_valid) begin
      grant[TAG_KS] = 1'b1;
    end
  end

  // rr_ptr names the requester preferred on the next tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= TAG_DP;
      starve_cnt <= '0;
    end else begin
      if (accept && (grant != 2'b00)) rr_ptr <= grant[TAG_DP] ? TAG_KS : TAG_DP;
      if (!dp_valid || (accept && grant[TAG_DP]))
        starve_cnt <= '0;
      else if (accept && grant[TAG_KS] && (STARVE_LIMIT != 0) && !starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aes_sbox_share_arbiter.sv
// Shares one 4-S-box SubBytes unit between the round datapath and key schedule (2-stage pipe).
module aes_sbox_share_arbiter
  import aes_sbox_share_arbiter_pkg::*;
#(
  parameter int KEY_PRIORITY = ARB_RR,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dp_req_valid,
  output logic        dp_req_ready,
  input  logic [31:0] dp_req_data,
  input  logic        dp_req_enc_dec,
  output logic        dp_rsp_valid,
  input  logic        dp_rsp_ready,
  output logic [31:0] dp_rsp_data,
  input  logic        ks_req_valid,
  output logic        ks_req_ready,
  input  logic [31:0] ks_req_data,
  output logic        ks_rsp_valid,
  input  logic        ks_rsp_ready,
  output logic [31:0] ks_rsp_data,
  output logic [31:0] sbox_in,
  output logic        sbox_enc_dec,
  input  logic [31:0] sbox_out,
  output logic        busy
);

  logic        s1_v, s1_enc_dec;
  tag_e        s1_tag;
  logic [31:0] s1_data;
  logic        s2_v;
  tag_e        s2_tag;
  logic [31:0] s2_data;

  logic        s2_adv, s1_free, accept;
  logic [1:0]  grant;

  assign s2_adv  = !s2_v || ((s2_tag == TAG_DP) ? dp_rsp_ready : ks_rsp_ready);
  assign s1_free = !s1_v || s2_adv;
  assign accept  = s1_free && rst_n;

  aes_sbox_share_arbiter_arb2 #(
    .KEY_PRIORITY(KEY_PRIORITY),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .dp_valid (dp_req_valid),
    .ks_valid (ks_req_valid),
    .accept   (accept),
    .grant    (grant)
  );

  assign dp_req_ready = grant[TAG_DP] && accept;
  assign ks_req_ready = grant[TAG_KS] && accept;

  // Empty stages are zeroed so the shared unit sees a static operand when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s1_tag     <= TAG_DP;
      s1_data    <= '0;
      s1_enc_dec <= 1'b1;
      s2_v       <= 1'b0;
      s2_tag     <= TAG_DP;
      s2_data    <= '0;
    end else begin
      if (dp_req_valid && dp_req_ready) begin
        s1_v       <= 1'b1;
        s1_tag     <= TAG_DP;
        s1_data    <= dp_req_data;
        s1_enc_dec <= dp_req_enc_dec;
      end else if (ks_req_valid && ks_req_ready) begin
        s1_v       <= 1'b1;
        s1_tag     <= TAG_KS;
        s1_data    <= ks_req_data;
        s1_enc_dec <= 1'b1;
      end else if (s1_free) begin
        s1_v       <= 1'b0;
        s1_tag     <= TAG_DP;
        s1_data    <= '0;
        s1_enc_dec <= 1'b1;
      end
      if (s2_adv) begin
        s2_v    <= s1_v;
        s2_tag  <= s1_tag;
        s2_data <= s1_v ? sbox_out : '0;
      end
    end
  end

  assign sbox_in      = s1_data;
  assign sbox_enc_dec = s1_enc_dec;
  assign dp_rsp_valid = s2_v && (s2_tag == TAG_DP);
  assign ks_rsp_valid = s2_v && (s2_tag == TAG_KS);
  assign dp_rsp_data  = s2_data;
  assign ks_rsp_data  = s2_data;
  assign busy         = s1_v || s2_v;

endmodule

// File: tb/tb_aes_sbox_share_arbiter.sv
// Scoreboard bench: GF(2^8) reference S-box model, directed corner cases plus random traffic.
module tb_aes_sbox_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        dp_req_valid, dp_req_enc_dec, dp_rsp_ready;
  logic [31:0] dp_req_data;
  logic        ks_req_valid, ks_rsp_ready;
  logic [31:0] ks_req_data;

  int checks   = 0;
  int failures = 0;
  logic [31:0] dp_q[$];
  logic [31:0] ks_q[$];

  // ---------------- reference S-box (field inverse + affine map) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq = a;
    logic [7:0] r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    d = d << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w, input logic enc);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = enc ? sbox_fwd(w[i*8 +: 8]) : sbox_inv(w[i*8 +: 8]);
    return r;
  endfunction

  // ---------------- three DUT instances sharing stimulus ----------------
  logic        rr_dp_req_ready, rr_dp_rsp_valid, rr_ks_req_ready, rr_ks_rsp_valid;
  logic [31:0] rr_dp_rsp_data, rr_ks_rsp_data, rr_sbox_in, rr_sbox_out;
  logic        rr_sbox_enc_dec, rr_busy;
  logic        k4_dp_req_ready, k4_dp_rsp_valid, k4_ks_req_ready, k4_ks_rsp_valid;
  logic [31:0] k4_dp_rsp_data, k4_ks_rsp_data, k4_sbox_in, k4_sbox_out;
  logic        k4_sbox_enc_dec, k4_busy;
  logic        k0_dp_req_ready, k0_dp_rsp_valid, k0_ks_req_ready, k0_ks_rsp_valid;
  logic [31:0] k0_dp_rsp_data, k0_ks_rsp_data, k0_sbox_in, k0_sbox_out;
  logic        k0_sbox_enc_dec, k0_busy;

  always @* rr_sbox_out = ref_word(rr_sbox_in, rr_sbox_enc_dec);
  always @* k4_sbox_out = ref_word(k4_sbox_in, k4_sbox_enc_dec);
  always @* k0_sbox_out = ref_word(k0_sbox_in, k0_sbox_enc_dec);

  aes_sbox_share_arbiter #(.KEY_PRIORITY(0), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .dp_req_valid(dp_req_valid), .dp_req_ready(rr_dp_req_ready), .dp_req_data(dp_req_data),
    .dp_req_enc_dec(dp_req_enc_dec), .dp_rsp_valid(rr_dp_rsp_valid), .dp_rsp_ready(dp_rsp_ready),
    .dp_rsp_data(rr_dp_rsp_data), .ks_req_valid(ks_req_valid), .ks_req_ready(rr_ks_req_ready),
    .ks_req_data(ks_req_data), .ks_rsp_valid(rr_ks_rsp_valid), .ks_rsp_ready(ks_rsp_ready),
    .ks_rsp_data(rr_ks_rsp_data), .sbox_in(rr_sbox_in), .sbox_enc_dec(rr_sbox_enc_dec),
    .sbox_out(rr_sbox_out), .busy(rr_busy));

  aes_sbox_share_arbiter #(.KEY_PRIORITY(1), .STARVE_LIMIT(4)) u_k4 (
    .clk(clk), .rst_n(rst_n),
    .dp_req_valid(dp_req_valid), .dp_req_ready(k4_dp_req_ready), .dp_req_data(dp_req_data),
    .dp_req_enc_dec(dp_req_enc_dec), .dp_rsp_valid(k4_dp_rsp_valid), .dp_rsp_ready(dp_rsp_ready),
    .dp_rsp_data(k4_dp_rsp_data), .ks_req_valid(ks_req_valid), .ks_req_ready(k4_ks_req_ready),
    .ks_req_data(ks_req_data), .ks_rsp_valid(k4_ks_rsp_valid), .ks_rsp_ready(ks_rsp_ready),
    .ks_rsp_data(k4_ks_rsp_data), .sbox_in(k4_sbox_in), .sbox_enc_dec(k4_sbox_enc_dec),
    .sbox_out(k4_sbox_out), .busy(k4_busy));

  aes_sbox_share_arbiter #(.KEY_PRIORITY(1), .STARVE_LIMIT(0)) u_k0 (
    .clk(clk), .rst_n(rst_n),
    .dp_req_valid(dp_req_valid), .dp_req_ready(k0_dp_req_ready), .dp_req_data(dp_req_data),
    .dp_req_enc_dec(dp_req_enc_dec), .dp_rsp_valid(k0_dp_rsp_valid), .dp_rsp_ready(dp_rsp_ready),
    .dp_rsp_data(k0_dp_rsp_data), .ks_req_valid(ks_req_valid), .ks_req_ready(k0_ks_req_ready),
    .ks_req_data(ks_req_data), .ks_rsp_valid(k0_ks_rsp_valid), .ks_rsp_ready(ks_rsp_ready),
    .ks_rsp_data(k0_ks_rsp_data), .sbox_in(k0_sbox_in), .sbox_enc_dec(k0_sbox_enc_dec),
    .sbox_out(k0_sbox_out), .busy(k0_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic smp();
    #4;
  endtask

  // ---------------- monitor / scoreboard on the round-robin instance ----------------
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      dp_q.delete();
      ks_q.delete();
    end else begin
      chk("ready_one_hot", {31'd0, rr_dp_req_ready & rr_ks_req_ready}, 32'd0);
      if (dp_req_valid && rr_dp_req_ready) dp_q.push_back(ref_word(dp_req_data, dp_req_enc_dec));
      if (ks_req_valid && rr_ks_req_ready) ks_q.push_back(ref_word(ks_req_data, 1'b1));
      if (rr_dp_rsp_valid && dp_rsp_ready) begin
        if (dp_q.size() == 0) chk("dp_rsp_unexpected", 32'(dp_q.size()), 32'd1);
        else chk("dp_rsp_data", rr_dp_rsp_data, dp_q.pop_front());
      end
      if (rr_ks_rsp_valid && ks_rsp_ready) begin
        if (ks_q.size() == 0) chk("ks_rsp_unexpected", 32'(ks_q.size()), 32'd1);
        else chk("ks_rsp_data", rr_ks_rsp_data, ks_q.pop_front());
      end
    end
  end

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      dp_req_valid = 1'b0;
      ks_req_valid = 1'b0;
      dp_rsp_ready = 1'b1;
      ks_rsp_ready = 1'b1;
      smp();
      if (!rr_busy && dp_q.size() == 0 && ks_q.size() == 0) done = 1'b1;
    end
    chk("drain_busy", {31'd0, rr_busy}, 32'd0);
    chk("drain_dp_q", 32'(dp_q.size()), 32'd0);
    chk("drain_ks_q", 32'(ks_q.size()), 32'd0);
  endtask

  task automatic dp_directed(input logic [31:0] d, input logic enc, input logic [31:0] lit);
    cyc();
    dp_req_valid = 1'b1; dp_req_data = d; dp_req_enc_dec = enc;
    smp();
    chk("dp_dir_accept", {31'd0, rr_dp_req_ready}, 32'd1);
    cyc();
    dp_req_valid = 1'b0;
    smp();
    chk("dp_dir_s1_in", rr_sbox_in, d);
    chk("dp_dir_early", {31'd0, rr_dp_rsp_valid}, 32'd0);
    cyc();
    smp();
    chk("dp_dir_valid", {31'd0, rr_dp_rsp_valid}, 32'd1);
    chk("dp_dir_literal", rr_dp_rsp_data, lit);
    chk("dp_dir_ks_quiet", {31'd0, rr_ks_rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, c, exp_a;
    logic        enc_a;
    int          cnt4;
    logic [1:0]  exp4;
    bit          dp_pend, ks_pend;

    rst_n = 1'b0;
    dp_req_valid = 1'b0; dp_req_data = '0; dp_req_enc_dec = 1'b1; dp_rsp_ready = 1'b1;
    ks_req_valid = 1'b0; ks_req_data = '0; ks_rsp_ready = 1'b1;

    // reset: readies held low even with valid requests
    cyc();
    dp_req_valid = 1'b1; ks_req_valid = 1'b1;
    smp();
    chk("reset_ready_rr", {30'd0, rr_dp_req_ready, rr_ks_req_ready}, 32'd0);
    chk("reset_ready_k4", {30'd0, k4_dp_req_ready, k4_ks_req_ready}, 32'd0);
    cyc();
    rst_n = 1'b1; dp_req_valid = 1'b0; ks_req_valid = 1'b0;
    smp();
    chk("reset_rsp_valid", {30'd0, rr_dp_rsp_valid, rr_ks_rsp_valid}, 32'd0);
    chk("reset_busy", {31'd0, rr_busy}, 32'd0);
    chk("reset_sbox_in", rr_sbox_in, 32'd0);
    chk("reset_sbox_enc", {31'd0, rr_sbox_enc_dec}, 32'd1);

    dp_directed(32'h00010253, 1'b1, 32'h637C77ED);
    dp_directed(32'h637C77ED, 1'b0, 32'h00010253);

    // KS always forward, even with the DP direction bit low
    cyc();
    dp_req_enc_dec = 1'b0; ks_req_valid = 1'b1; ks_req_data = 32'h637C77ED;
    smp();
    chk("ks_dir_accept", {31'd0, rr_ks_req_ready}, 32'd1);
    cyc();
    ks_req_valid = 1'b0;
    smp();
    chk("ks_dir_s1_enc", {31'd0, rr_sbox_enc_dec}, 32'd1);
    chk("ks_dir_s1_in", rr_sbox_in, 32'h637C77ED);
    cyc();
    smp();
    chk("ks_dir_valid", {31'd0, rr_ks_rsp_valid}, 32'd1);
    chk("ks_dir_data", rr_ks_rsp_data, ref_word(32'h637C77ED, 1'b1));
    drain();

    // back-pressure on DP result
    a = $urandom; b = $urandom; c = $urandom; enc_a = 1'($urandom);
    exp_a = ref_word(a, enc_a);
    cyc();
    dp_rsp_ready = 1'b0; dp_req_valid = 1'b1; dp_req_data = a; dp_req_enc_dec = enc_a;
    smp();
    chk("bp_accept_a", {30'd0, rr_dp_req_ready, rr_ks_req_ready}, 32'd2);
    cyc();
    dp_req_data = b; dp_req_enc_dec = 1'($urandom); ks_req_valid = 1'b1; ks_req_data = c;
    smp();
    chk("bp_accept_c", {30'd0, rr_dp_req_ready, rr_ks_req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      ks_req_valid = 1'b0;
      smp();
      chk("bp_ready_low", {30'd0, rr_dp_req_ready, rr_ks_req_ready}, 32'd0);
      chk("bp_busy", {31'd0, rr_busy}, 32'd1);
      chk("bp_rsp_valid", {31'd0, rr_dp_rsp_valid}, 32'd1);
      chk("bp_rsp_held", rr_dp_rsp_data, exp_a);
    end
    cyc();
    dp_rsp_ready = 1'b1;
    smp();
    chk("bp_release_b", {30'd0, rr_dp_req_ready, rr_ks_req_ready}, 32'd2);
    drain();

    // fill both stages, reset for one cycle, then arbitration sequences
    cyc();
    dp_rsp_ready = 1'b0; ks_rsp_ready = 1'b0;
    dp_req_valid = 1'b1; dp_req_data = $urandom; dp_req_enc_dec = 1'($urandom);
    ks_req_valid = 1'b1; ks_req_data = $urandom;
    repeat (3) cyc();
    smp();
    chk("full_busy", {31'd0, rr_busy}, 32'd1);
    cyc();
    rst_n = 1'b0;
    smp();
    chk("midreset_ready", {30'd0, rr_dp_req_ready, rr_ks_req_ready}, 32'd0);
    cyc();
    rst_n = 1'b1; dp_rsp_ready = 1'b1; ks_rsp_ready = 1'b1;
    cnt4 = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cyc();
      smp();
      if (i == 0) begin
        chk("postrst_rsp_valid", {30'd0, rr_dp_rsp_valid, rr_ks_rsp_valid}, 32'd0);
        chk("postrst_busy", {31'd0, rr_busy}, 32'd0);
        chk("postrst_sbox_in", rr_sbox_in, 32'd0);
      end
      if (i < 8)
        chk("rr_grant", {30'd0, rr_dp_req_ready, rr_ks_req_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
      exp4 = (cnt4 == 4) ? 2'b10 : 2'b01;
      chk("kp4_grant", {30'd0, k4_dp_req_ready, k4_ks_req_ready}, {30'd0, exp4});
      cnt4 = (exp4 == 2'b10) ? 0 : cnt4 + 1;
      chk("kp0_grant", {30'd0, k0_dp_req_ready, k0_ks_req_ready}, 32'd1);
    end
    drain();

    // randomized traffic with random response back-pressure
    dp_pend = 1'b0; ks_pend = 1'b0;
    repeat (3000) begin
      cyc();
      if (!dp_pend) begin
        dp_req_valid = ($urandom % 100) < 60;
        dp_req_data = $urandom;
        dp_req_enc_dec = 1'($urandom);
        dp_pend = dp_req_valid;
      end
      if (!ks_pend) begin
        ks_req_valid = ($urandom % 100) < 60;
        ks_req_data = $urandom;
        ks_pend = ks_req_valid;
      end
      dp_rsp_ready = ($urandom % 4) != 0;
      ks_rsp_ready = ($urandom % 4) != 0;
      smp();
      if (dp_req_valid && rr_dp_req_ready) dp_pend = 1'b0;
      if (ks_req_valid && rr_ks_req_ready) ks_pend = 1'b0;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
